// File: rtl/dram_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter and the MEM stage that feeds it.
package dram_arbiter_pkg;

  // Default bus widths, also picked up by the MEM stage.
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Who currently drives the single-port data RAM.
  typedef enum logic {
    CPU_OWN = 1'b0,
    EXT_OWN = 1'b1
  } arb_state_e;

  // Bits needed to count from 0 up to and including 'limit' (at least one bit).
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/dram_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; flags when it sits at LIMIT.
module sat_counter
  import dram_arbiter_pkg::*;
#(
  parameter int LIMIT = 7,
  parameter int WIDTH = cnt_width(LIMIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_lim_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign at_lim_o = (cnt_q == WIDTH'(LIMIT));

  // Next count: clear wins over increment, increment stops at LIMIT.
  always_comb begin
    // NOTE: default assignment first so no path leaves cnt_d unassigned (no latch).
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_lim_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments in clocked blocks avoid read/write ordering races.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Arbitrates the single-port data RAM between the CPU MEM stage (priority)
// and an external loader/debug port, with starvation and burst limits.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_LIM = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_owner,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  arb_state_e        state_q, state_d;
  logic              ext_own, ext_xfer;
  logic              starve_inc, starve_clr, starve_at_lim;
  logic              burst_inc, burst_clr, burst_at_lim;
  logic              ext_rvalid_q;
  logic [DATA_W-1:0] ext_rdata_q;

  assign ext_own  = (state_q == EXT_OWN);
  assign ext_xfer = ext_own & ext_req;

  // RAM port follows the owner; CPU writes can only reach the RAM in CPU_OWN,
  // so a stalled store is replayed later rather than duplicated.
  assign ram_addr = ext_own ? ext_addr  : cpu_addr;
  assign ram_din  = ext_own ? ext_wdata : cpu_wdata;
  assign ram_we   = ext_own ? (ext_req & ext_we) : (cpu_req & cpu_we);

  // Stall depends on ext_* only through the registered state.
  assign cpu_rdata  = ram_dout;
  assign cpu_stall  = ext_own & cpu_req;
  assign ext_gnt    = ext_xfer;
  assign ext_owner  = ext_own;
  assign ext_rvalid = ext_rvalid_q;
  assign ext_rdata  = ext_rdata_q;

  // Ownership decision: ext takes an idle RAM or one it has waited too long for;
  // it gives it back when it goes idle or exhausts its burst against a waiting CPU.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CPU_OWN: if (ext_req && (!cpu_req || starve_at_lim)) state_d = EXT_OWN;
      EXT_OWN: if (!ext_req || (cpu_req && burst_at_lim))  state_d = CPU_OWN;
      default: state_d = CPU_OWN;
    endcase
  end

  // Starvation counts contended CPU_OWN cycles; burst counts transfers made
  // while the CPU waits. Both restart whenever ownership changes.
  assign starve_inc = !ext_own & ext_req & cpu_req;
  assign starve_clr = !starve_inc | (state_d == EXT_OWN);
  assign burst_inc  = ext_xfer & cpu_req;
  assign burst_clr  = (state_d == CPU_OWN);

  sat_counter #(.LIMIT(STARVE_LIM - 1)) u_starve_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (starve_inc),
    .clr_i    (starve_clr),
    .at_lim_o (starve_at_lim)
  );

  sat_counter #(.LIMIT(MAX_BURST - 1)) u_burst_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (burst_inc),
    .clr_i    (burst_clr),
    .at_lim_o (burst_at_lim)
  );

  // Ownership state plus registered read return for the external port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= CPU_OWN;
      ext_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      ext_rvalid_q <= ext_xfer & !ext_we;
      if (ext_xfer && !ext_we) begin
        ext_rdata_q <= ram_dout;
      end
    end
  end

endmodule
